// File: rtl/sbox_share_ctrl.sv
// Time-multiplexed SubBytes controller: one 32-bit S-box bank shared between
// the round datapath (four beats per 128-bit state) and key expansion (one beat per word).
module sbox_share_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_valid_in,
  output logic         st_ready,
  input  logic [127:0] st_data_in,
  output logic         st_valid_out,
  output logic [127:0] st_data_out,
  input  logic         kw_valid_in,
  output logic         kw_ready,
  input  logic [31:0]  kw_data_in,
  output logic         kw_valid_out,
  output logic [31:0]  kw_data_out,
  output logic [31:0]  sbox_data_in,
  input  logic [31:0]  sbox_data_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ST_BEAT = 2'd1,
    KW_BEAT = 2'd2
  } state_e;

  localparam logic GRANT_STATE = 1'b0;
  localparam logic GRANT_KEY   = 1'b1;

  state_e       state_r;
  state_e       state_nxt_s;
  logic [1:0]   beat_r;
  logic [1:0]   beat_nxt_s;
  logic [127:0] work_r;
  logic         last_grant_r;
  logic         grant_key_s;
  logic         st_fire_s;
  logic         kw_fire_s;

  // Round-robin arbiter: on a tie the requester not granted last time wins.
  always_comb begin
    grant_key_s = 1'b0;
    st_ready    = 1'b0;
    kw_ready    = 1'b0;
    if (state_r == IDLE) begin
      if (st_valid_in && kw_valid_in) begin
        grant_key_s = (last_grant_r == GRANT_STATE);
      end else begin
        grant_key_s = kw_valid_in;
      end
      kw_ready = kw_valid_in && grant_key_s;
      st_ready = st_valid_in && !grant_key_s;
    end else begin
      grant_key_s = 1'b0;
    end
  end

  assign st_fire_s = st_valid_in && st_ready;
  assign kw_fire_s = kw_valid_in && kw_ready;

  // Next-state and beat counter logic.
  always_comb begin
    state_nxt_s = state_r;
    beat_nxt_s  = beat_r;
    case (state_r)
      IDLE: begin
        if (st_fire_s) begin
          state_nxt_s = ST_BEAT;
          beat_nxt_s  = 2'd0;
        end else if (kw_fire_s) begin
          state_nxt_s = KW_BEAT;
          beat_nxt_s  = 2'd0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ST_BEAT: begin
        if (beat_r == 2'd3) begin
          state_nxt_s = IDLE;
          beat_nxt_s  = 2'd0;
        end else begin
          beat_nxt_s = beat_r + 2'd1;
        end
      end
      KW_BEAT: begin
        state_nxt_s = IDLE;
        beat_nxt_s  = 2'd0;
      end
      default: begin
        state_nxt_s = IDLE;
        beat_nxt_s  = 2'd0;
      end
    endcase
  end

  // S-box bank feed: driven only from registered state, zero when idle.
  always_comb begin
    sbox_data_in = 32'h0000_0000;
    case (state_r)
      ST_BEAT: begin
        case (beat_r)
          2'd0:    sbox_data_in = work_r[31:0];
          2'd1:    sbox_data_in = work_r[63:32];
          2'd2:    sbox_data_in = work_r[95:64];
          2'd3:    sbox_data_in = work_r[127:96];
          default: sbox_data_in = 32'h0000_0000;
        endcase
      end
      KW_BEAT: sbox_data_in = work_r[31:0];
      default: sbox_data_in = 32'h0000_0000;
    endcase
  end

  // FSM state, beat counter and arbitration history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      beat_r       <= 2'd0;
      last_grant_r <= GRANT_STATE;
    end else begin
      state_r <= state_nxt_s;
      beat_r  <= beat_nxt_s;
      if (st_fire_s) begin
        last_grant_r <= GRANT_STATE;
      end else if (kw_fire_s) begin
        last_grant_r <= GRANT_KEY;
      end
    end
  end

  // Work register; a key word only occupies the low lane.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_r <= 128'h0;
    end else if (st_fire_s) begin
      work_r <= st_data_in;
    end else if (kw_fire_s) begin
      work_r <= {96'h0, kw_data_in};
    end
  end

  // Result capture and completion pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_data_out  <= 128'h0;
      kw_data_out  <= 32'h0000_0000;
      st_valid_out <= 1'b0;
      kw_valid_out <= 1'b0;
    end else begin
      st_valid_out <= (state_r == ST_BEAT) && (beat_r == 2'd3);
      kw_valid_out <= (state_r == KW_BEAT);
      if (state_r == ST_BEAT) begin
        case (beat_r)
          2'd0:    st_data_out[31:0]   <= sbox_data_out;
          2'd1:    st_data_out[63:32]  <= sbox_data_out;
          2'd2:    st_data_out[95:64]  <= sbox_data_out;
          2'd3:    st_data_out[127:96] <= sbox_data_out;
          default: st_data_out         <= st_data_out;
        endcase
      end
      if (state_r == KW_BEAT) begin
        kw_data_out <= sbox_data_out;
      end
    end
  end

endmodule
